// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared ROB entry layout, widths and commit FSM states
package sys_defs;
  localparam int XLEN        = 32;
  localparam int ROB_TAG_LEN = 5;
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic            valid;
    logic            wr_mem;
    logic [4:0]      dest_reg;
    logic [XLEN-1:0] value;
    logic [XLEN-1:0] dest_addr;
    logic            ready;
  } ROB_ENTRY;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} COMMIT_STATE;
endpackage

// File: rtl/commit_store_fsm.sv
// rtl/commit_store_fsm.sv - store retirement FSM with req/ack handshake, timeout timer and addr/data latches
module commit_store_fsm
  import sys_defs::*;
#(
  parameter int STORE_TIMEOUT = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] data_i,
  input  logic            mem_ack_i,
  output logic            idle_o,
  output logic            ack_o,
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_data_o,
  output logic            store_err_o
);
  localparam int TW = $clog2(STORE_TIMEOUT);
  localparam logic [TW-1:0] LAST = TW'(STORE_TIMEOUT - 1);

  COMMIT_STATE     state_q, state_d;
  logic [TW-1:0]   timer_q;
  logic [XLEN-1:0] addr_q, data_q;
  logic            err_q;
  logic            timeout;

  assign timeout = (state_q == ST_WAIT) && !mem_ack_i && (timer_q == LAST);

  always_comb begin
    state_d = state_q;
    ack_o   = 1'b0;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_REQ;
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_ack_i) begin
          ack_o   = 1'b1;
          state_d = ST_IDLE;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      // Latch once at issue so later head changes cannot disturb the bus
      if (state_q == ST_IDLE && start_i) begin
        addr_q <= addr_i;
        data_q <= data_i;
      end
      if (state_q == ST_REQ) timer_q <= '0;
      else if (state_q == ST_WAIT && timer_q != '1) timer_q <= timer_q + TW'(1);
      if (timeout) err_q <= 1'b1;
    end
  end

  assign idle_o      = (state_q == ST_IDLE);
  assign mem_req_o   = (state_q != ST_IDLE);
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = data_q;
  assign store_err_o = err_q;
endmodule

// File: rtl/commit_unit.sv
// rtl/commit_unit.sv - in-order ROB head retirement: regfile/map-table writes and stores
// Define COMMIT_STATS_EN to build the retired_cnt counter; otherwise it is tied to 0.
module commit_unit
  import sys_defs::*;
#(
  parameter int STORE_TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  ROB_ENTRY               head_entry,
  input  logic [ROB_TAG_LEN-1:0] head_tag,
  input  logic                   mem_ack,
  output logic                   commit_ack,
  output logic                   rf_wr_en,
  output logic [4:0]             rf_wr_idx,
  output logic [XLEN-1:0]        rf_wr_data,
  output logic                   mt_clr_en,
  output logic [ROB_TAG_LEN-1:0] mt_clr_tag,
  output logic                   mem_req,
  output logic [XLEN-1:0]        mem_addr,
  output logic [XLEN-1:0]        mem_data,
  output logic                   store_err,
  output logic [31:0]            retired_cnt
);
  logic                   blk_q;
  logic                   rf_wr_en_q, mt_clr_en_q;
  logic [4:0]             rf_wr_idx_q;
  logic [XLEN-1:0]        rf_wr_data_q;
  logic [ROB_TAG_LEN-1:0] mt_clr_tag_q;
  logic                   idle, ok, head_rdy, alu_commit, store_start, store_ack;

  // blk_q inserts the idle cycle after any retirement while the ROB head advances
  assign ok          = !reset && !blk_q && idle;
  assign head_rdy    = head_entry.valid && head_entry.ready;
  assign alu_commit  = ok && head_rdy && !head_entry.wr_mem;
  assign store_start = ok && head_rdy && head_entry.wr_mem;
  assign commit_ack  = alu_commit || (store_ack && !reset);

  commit_store_fsm #(.STORE_TIMEOUT(STORE_TIMEOUT)) u_store (
    .clock       (clock),
    .reset       (reset),
    .start_i     (store_start),
    .addr_i      (head_entry.dest_addr),
    .data_i      (head_entry.value),
    .mem_ack_i   (mem_ack),
    .idle_o      (idle),
    .ack_o       (store_ack),
    .mem_req_o   (mem_req),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_data),
    .store_err_o (store_err)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      blk_q        <= 1'b0;
      rf_wr_en_q   <= 1'b0;
      mt_clr_en_q  <= 1'b0;
      rf_wr_idx_q  <= '0;
      rf_wr_data_q <= '0;
      mt_clr_tag_q <= '0;
    end else begin
      blk_q       <= commit_ack;
      rf_wr_en_q  <= alu_commit && (head_entry.dest_reg != ZERO_REG);
      mt_clr_en_q <= alu_commit && (head_entry.dest_reg != ZERO_REG);
      if (alu_commit) begin
        rf_wr_idx_q  <= head_entry.dest_reg;
        rf_wr_data_q <= head_entry.value;
        mt_clr_tag_q <= head_tag;
      end
    end
  end

  assign rf_wr_en   = rf_wr_en_q;
  assign rf_wr_idx  = rf_wr_idx_q;
  assign rf_wr_data = rf_wr_data_q;
  assign mt_clr_en  = mt_clr_en_q;
  assign mt_clr_tag = mt_clr_tag_q;

`ifdef COMMIT_STATS_EN
  logic [31:0] cnt_q;
  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else if (commit_ack) cnt_q <= cnt_q + 32'd1;
  end
  assign retired_cnt = cnt_q;
`else
  assign retired_cnt = '0;
`endif
endmodule
